// File: rtl/button_capture_pkg.sv
// Shared constants for the push-button input stage and the I/O manager
// that reads it.
package button_capture_pkg;

    // Memory-mapped I/O addresses decoded by the I/O manager.
    localparam logic [15:0] BUTTON_ADDR    = 16'hFFFD;
    localparam logic [15:0] LED_RED_ADDR   = 16'hFFFE;
    localparam logic [15:0] LED_GREEN_ADDR = 16'hFFFF;

    // Board defaults: four keys, 5 ms debounce at 50 MHz.
    localparam int unsigned DEFAULT_N_BUTTONS       = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEFAULT_CNT_W           = 18;

    // Idle level of a raw, active-low key.
    localparam logic RAW_IDLE = 1'b1;

endpackage : button_capture_pkg

// File: rtl/button_capture_debounce_cell.sv
// One push-button: two-flop synchroniser, debounce counter, stable level
// register and a one-cycle press indication.
module debounce_cell
    import button_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    // Count value at which a differing sample has been seen for
    // DEBOUNCE_CYCLES consecutive edges.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             sample;
    logic             stable;
    logic [CNT_W-1:0] count;
    logic             differs;
    logic             at_limit;

    // Two-flop synchroniser; resets to the idle (released) level so no
    // phantom press appears when reset is removed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Keys are active-low on the board; everything downstream is active-high.
    assign sample   = ~sync2;
    assign differs  = (sample != stable);
    assign at_limit = (count == LIMIT);

    // Debounce: any agreement with the stable level restarts the count,
    // and the counter is cleared on the accept edge so it never passes LIMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (!differs) begin
            count  <= '0;
        end else if (at_limit) begin
            stable <= sample;
            count  <= '0;
        end else begin
            count  <= count + CNT_W'(1);
        end
    end

    assign level = stable;

    // High during the cycle whose rising edge accepts a 0->1 transition,
    // so the sticky flag sets on the same edge as the level.
    assign press = differs && at_limit && sample;

endmodule : debounce_cell

// File: rtl/button_capture.sv
// Button input stage in front of the I/O manager's read port at BUTTON_ADDR:
// per-key synchronise and debounce, sticky press flags cleared on CPU read.
//
// rd_clr is a bare one-cycle strobe (no valid/ready): every rising edge on
// which it is high clears all flags, except that a press accepted on that
// same edge still sets its flag, so no press is lost across a read.
module button_capture
    import button_capture_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = DEFAULT_N_BUTTONS,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    input  logic                 rd_clr,
    output logic [N_BUTTONS-1:0] buttons_level,
    output logic [N_BUTTONS-1:0] buttons_event,
    output logic                 event_pending
);

    logic [N_BUTTONS-1:0] press;
    logic [N_BUTTONS-1:0] events;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .raw   (buttons_raw[i]),
            .level (buttons_level[i]),
            .press (press[i])
        );
    end

    // Sticky flags: clear on read, with a simultaneous press taking priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            events <= '0;
        end else begin
            events <= (rd_clr ? '0 : events) | press;
        end
    end

    assign buttons_event = events;
    assign event_pending = |events;

endmodule : button_capture
